// File: rtl/alu_req_sequencer.sv
// alu_req_sequencer: FIFO-buffered request feeder that runs one operation at a time through the ALU cs/rdy handshake.
// Optional stalled-ALU watchdog (TMO_CYCLES, rsp_timeout port) is compiled in with `define ALU_SEQ_TIMEOUT_EN.
module alu_req_sequencer #(
    parameter int DATA_W     = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int TMO_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [DATA_W-1:0] req_a,
    input  logic [DATA_W-1:0] req_b,
    input  logic [2:0]        req_op,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_cout,
    output logic [2:0]        rsp_op,
    output logic              rsp_illegal,
`ifdef ALU_SEQ_TIMEOUT_EN
    output logic              rsp_timeout,
`endif
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    output logic              alu_cs,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_cout,
    input  logic              alu_rdy,
    output logic              busy
);

    // state     | meaning
    // IDLE      | waiting for a FIFO entry and alu_rdy=1; pops here only
    // ISSUE     | alu_cs high until the ALU drops rdy (accepted)
    // WAIT_DONE | operands held, waiting for rdy to return with the result
    // RESP      | response presented until rsp_ready

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);
    localparam logic [2:0] OP_ILLEGAL = 3'd3;

    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("FIFO_DEPTH must be a power of two, at least 2");
    end
    if (TMO_CYCLES < 1) begin : g_bad_tmo
        $error("TMO_CYCLES must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DONE = 2'd2,
        RESP      = 2'd3
    } state_t;

    state_t state, state_nx;

    logic [DATA_W-1:0] fifo_a  [FIFO_DEPTH];
    logic [DATA_W-1:0] fifo_b  [FIFO_DEPTH];
    logic [2:0]        fifo_op [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, empty, push, pop, head_illegal, done;

    assign full         = (count == FULL_CNT);
    assign empty        = (count == '0);
    assign req_ready    = !full;
    assign push         = req_valid && !full;
    assign pop          = (state == IDLE) && !empty && alu_rdy;
    assign head_illegal = (fifo_op[rd_ptr] == OP_ILLEGAL);
    assign done         = (state == WAIT_DONE) && alu_rdy;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_a[wr_ptr]  <= req_a;
            fifo_b[wr_ptr]  <= req_b;
            fifo_op[wr_ptr] <= req_op;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ALU_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO_CYCLES + 1);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO_CYCLES - 1);

    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;

    // A completion arriving on the terminal cycle still wins over the timeout.
    assign tmo_hit = ((state == ISSUE) || (state == WAIT_DONE)) && (tmo_cnt == '0) && !done;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmo_cnt <= '0;
        end else if (pop && !head_illegal) begin
            tmo_cnt <= TMO_LOAD;
        end else if (((state == ISSUE) || (state == WAIT_DONE)) && (tmo_cnt != '0)) begin
            tmo_cnt <= tmo_cnt - 1'b1;
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (pop) state_nx = head_illegal ? RESP : ISSUE;
            end
            ISSUE: begin
`ifdef ALU_SEQ_TIMEOUT_EN
                if (tmo_hit)       state_nx = RESP;
                else if (!alu_rdy) state_nx = WAIT_DONE;
`else
                if (!alu_rdy) state_nx = WAIT_DONE;
`endif
            end
            WAIT_DONE: begin
`ifdef ALU_SEQ_TIMEOUT_EN
                if (done || tmo_hit) state_nx = RESP;
`else
                if (done) state_nx = RESP;
`endif
            end
            RESP: begin
                if (rsp_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        alu_cs    = (state == ISSUE);
        rsp_valid = (state == RESP);
        busy      = (state != IDLE) || !empty;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a       <= '0;
            alu_b       <= '0;
            alu_op      <= '0;
            rsp_data    <= '0;
            rsp_cout    <= 1'b0;
            rsp_op      <= '0;
            rsp_illegal <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
            rsp_timeout <= 1'b0;
`endif
        end else begin
            if (pop) begin
                rsp_op <= fifo_op[rd_ptr];
                if (head_illegal) begin
                    rsp_data    <= '0;
                    rsp_cout    <= 1'b0;
                    rsp_illegal <= 1'b1;
`ifdef ALU_SEQ_TIMEOUT_EN
                    rsp_timeout <= 1'b0;
`endif
                end else begin
                    alu_a  <= fifo_a[rd_ptr];
                    alu_b  <= fifo_b[rd_ptr];
                    alu_op <= fifo_op[rd_ptr];
                end
            end
            if (done) begin
                rsp_data    <= alu_out;
                rsp_cout    <= alu_cout && (alu_op[2:1] == 2'b00);
                rsp_illegal <= 1'b0;
`ifdef ALU_SEQ_TIMEOUT_EN
                rsp_timeout <= 1'b0;
`endif
            end
`ifdef ALU_SEQ_TIMEOUT_EN
            if (tmo_hit) begin
                rsp_data    <= '0;
                rsp_cout    <= 1'b0;
                rsp_illegal <= 1'b0;
                rsp_timeout <= 1'b1;
            end
`endif
        end
    end

endmodule
